// File: rtl/im_fetch_ctrl.sv
// Instruction-fetch sequencer for the 16-bit core.
// Drives the instruction memory address/read-enable, buffers returned words
// in a 2-entry queue ahead of decode, and handles redirects, HALT detection
// and PC wrap-around.
module im_fetch_ctrl #(
  parameter int                ADDR_W      = 16,
  parameter int                DATA_W      = 16,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [3:0]        HALT_OPCODE = 4'hF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              id_ready,
  input  logic [DATA_W-1:0] im_instr,
  output logic [ADDR_W-1:0] im_addr,
  output logic              im_rd_en,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_plus1,
  output logic              halted
);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_FETCH,
    ST_HALT
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] fetch_pc;
  logic [1:0]        count;

  // Queue storage: entry 0 is the head presented to decode.
  logic [DATA_W-1:0] q_instr0;
  logic [DATA_W-1:0] q_instr1;
  logic [ADDR_W-1:0] q_pc0;
  logic [ADDR_W-1:0] q_pc1;

  logic pop;
  logic push;
  logic halt_word;

  assign halt_word = (im_instr[DATA_W-1 -: 4] == HALT_OPCODE);

  // Next-state and read-enable decode; a redirect suppresses the request and
  // forces FETCH so the new target is requested on the following cycle.
  always_comb begin
    state_nxt = state;
    im_rd_en  = 1'b0;
    pop       = (count != 2'd0) && id_ready && !redirect;
    case (state)
      ST_INIT: begin
        state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        im_rd_en = !redirect && ((count < 2'd2) || pop);
        if (im_rd_en && halt_word) begin
          state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        state_nxt = ST_HALT;
      end
      default: begin
        state_nxt = ST_INIT;
      end
    endcase
    if (redirect) begin
      state_nxt = ST_FETCH;
    end
  end

  assign push = im_rd_en;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Fetch PC and queue bookkeeping; redirect flushes and discards any
  // same-cycle push or pop, and an empty queue keeps its last head fields.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      count    <= 2'd0;
      q_instr0 <= '0;
      q_instr1 <= '0;
      q_pc0    <= '0;
      q_pc1    <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      count    <= 2'd0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + ADDR_W'(1);
      end
      case ({push, pop})
        2'b11: begin
          if (count == 2'd1) begin
            q_instr0 <= im_instr;
            q_pc0    <= fetch_pc;
          end else begin
            q_instr0 <= q_instr1;
            q_pc0    <= q_pc1;
            q_instr1 <= im_instr;
            q_pc1    <= fetch_pc;
          end
        end
        2'b10: begin
          if (count == 2'd0) begin
            q_instr0 <= im_instr;
            q_pc0    <= fetch_pc;
          end else begin
            q_instr1 <= im_instr;
            q_pc1    <= fetch_pc;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) begin
            q_instr0 <= q_instr1;
            q_pc0    <= q_pc1;
          end
          count <= count - 2'd1;
        end
        default: begin
          count <= count;
        end
      endcase
    end
  end

  assign im_addr     = fetch_pc;
  assign if_valid    = (count != 2'd0);
  assign if_instr    = q_instr0;
  assign if_pc       = q_pc0;
  assign if_pc_plus1 = q_pc0 + ADDR_W'(1);
  assign halted      = (state == ST_HALT) && (count == 2'd0);

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Self-checking bench for im_fetch_ctrl: directed scenarios followed by a
// randomized phase, all checked against a queue-based reference model.
module tb_im_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        id_ready;
  logic [15:0] im_instr;
  logic [15:0] im_addr;
  logic        im_rd_en;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic [15:0] if_pc_plus1;
  logic        halted;

  im_fetch_ctrl #(
    .ADDR_W(16),
    .DATA_W(16),
    .RESET_PC(16'h0000),
    .HALT_OPCODE(4'hF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .id_ready(id_ready),
    .im_instr(im_instr),
    .im_addr(im_addr),
    .im_rd_en(im_rd_en),
    .if_valid(if_valid),
    .if_instr(if_instr),
    .if_pc(if_pc),
    .if_pc_plus1(if_pc_plus1),
    .halted(halted)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } entry_t;

  logic [15:0] mem [0:65535];

  // Reference model: the fetched-but-not-decoded words, the next fetch
  // address, and whether fetching is idle after reset or stopped on HALT.
  entry_t      mq[$];
  logic [15:0] m_pc;
  bit          m_init;
  bit          m_halt;
  bit          m_reset_hold;

  int n_cmp = 0;
  int n_bad = 0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance the
  // model by what the rising edge should do.
  task automatic applyStimulus(input bit rst, input bit redir, input logic [15:0] rpc, input bit rdy);
    bit     exp_rd;
    int     sz;
    entry_t e;
    rst_n       = rst;
    redirect    = redir;
    redirect_pc = rpc;
    id_ready    = rdy;
    im_instr    = mem[im_addr];
    @(negedge clk);
    sz     = mq.size();
    exp_rd = !m_init && !m_halt && !redir && ((sz < 2) || ((sz > 0) && rdy));
    checkOutput("im_rd_en", 32'(im_rd_en), 32'(exp_rd));
    checkOutput("im_addr", 32'(im_addr), 32'(m_pc));
    checkOutput("if_valid", 32'(if_valid), 32'(sz != 0));
    checkOutput("halted", 32'(halted), 32'(m_halt && (sz == 0)));
    if (sz > 0) begin
      checkOutput("if_instr", 32'(if_instr), 32'(mq[0].instr));
      checkOutput("if_pc", 32'(if_pc), 32'(mq[0].pc));
      checkOutput("if_pc_plus1", 32'(if_pc_plus1), 32'(16'(mq[0].pc + 16'd1)));
    end else if (m_reset_hold) begin
      checkOutput("rst_if_instr", 32'(if_instr), 32'h0);
      checkOutput("rst_if_pc", 32'(if_pc), 32'h0);
      checkOutput("rst_if_pc_plus1", 32'(if_pc_plus1), 32'h1);
    end
    @(posedge clk);
    if (!rst) begin
      mq.delete();
      m_pc         = 16'h0000;
      m_init       = 1'b1;
      m_halt       = 1'b0;
      m_reset_hold = 1'b1;
    end else if (redir) begin
      mq.delete();
      m_pc   = rpc;
      m_init = 1'b0;
      m_halt = 1'b0;
    end else begin
      if ((sz > 0) && rdy) begin
        void'(mq.pop_front());
      end
      if (exp_rd) begin
        e.instr = mem[m_pc];
        e.pc    = m_pc;
        mq.push_back(e);
        m_pc         = m_pc + 16'd1;
        m_reset_hold = 1'b0;
        if (e.instr[15:12] == 4'hF) begin
          m_halt = 1'b1;
        end
      end
      m_init = 1'b0;
    end
    #1;
  endtask

  task automatic runCycles(input int n, input bit rdy);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 1'b0, 16'h0000, rdy);
    end
  endtask

  initial begin
    bit          r_rst;
    bit          r_redir;
    bit          r_rdy;
    logic [15:0] r_pc;

    for (int i = 0; i < 65536; i++) begin
      mem[i] = {4'(1 + (i % 14)), 12'(i)};
    end
    mem[16'h0000] = 16'h1111;
    mem[16'h0001] = 16'h2222;
    mem[16'h0002] = 16'h3333;
    mem[16'h0003] = 16'h4444;
    mem[16'h0005] = 16'hF000;
    mem[16'h0081] = 16'hF123;
    mem[16'hFFFF] = 16'hABCD;

    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    id_ready    = 1'b0;
    im_instr    = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    m_pc         = 16'h0000;
    m_init       = 1'b1;
    m_halt       = 1'b0;
    m_reset_hold = 1'b1;

    // Reset release and streaming, then a decode stall that fills the queue.
    runCycles(3, 1'b1);
    runCycles(5, 1'b0);
    // Resume: runs into the HALT word at address 5 and drains.
    runCycles(10, 1'b1);
    // Redirect out of HALT, then fill the queue.
    applyStimulus(1'b1, 1'b1, 16'h0010, 1'b1);
    runCycles(3, 1'b1);
    runCycles(3, 1'b0);
    // Redirect while full with decode ready.
    applyStimulus(1'b1, 1'b1, 16'h0040, 1'b1);
    runCycles(4, 1'b1);
    // Wrap-around at the top of the address space.
    applyStimulus(1'b1, 1'b1, 16'hFFFF, 1'b1);
    runCycles(4, 1'b1);
    // Full queue in HALT, then a one-cycle reset.
    applyStimulus(1'b1, 1'b1, 16'h0080, 1'b0);
    runCycles(4, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    runCycles(6, 1'b1);

    // Randomized traffic with sprinkled HALT words.
    for (int i = 0; i < 40; i++) begin
      mem[$urandom_range(16'h0100, 16'h01FF)] = {4'hF, 12'($urandom)};
    end
    for (int i = 0; i < 800; i++) begin
      r_rst   = ($urandom_range(0, 63) != 0);
      r_redir = r_rst && ($urandom_range(0, 15) == 0);
      r_pc    = ($urandom_range(0, 7) == 0) ? 16'hFFFE : 16'($urandom_range(16'h0100, 16'h01FF));
      r_rdy   = ($urandom_range(0, 3) != 0);
      applyStimulus(r_rst, r_redir, r_pc, r_rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
